// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// instruction/PC widths, the bubble instruction and the PC step.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_W      = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [PC_W-1:0]    PC_INC    = 32'd4;

    // REQ: issue a request; WAIT: request outstanding; HOLD: fetched word
    // parked in the hold buffer until IF/ID drains the output slot.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Output slot presented to IF/ID plus a one-entry hold buffer that parks a
// fetched word while the slot is still occupied.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   i_invalidate     flush slot and hold buffer (branch redirect)
//   i_load_slot      write {i_pc, i_instr} directly into the slot
//   i_load_hold      write {i_pc, i_instr} into the hold buffer
//   i_hold_to_slot   move the hold buffer into the slot
//   i_consume        IF/ID takes the slot this cycle
//   i_pc, i_instr    incoming fetched pair
//   o_pc, o_instr,   slot contents presented to IF/ID
//   o_valid
// -----------------------------------------------------------------------------
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_invalidate,
    input  logic               i_load_slot,
    input  logic               i_load_hold,
    input  logic               i_hold_to_slot,
    input  logic               i_consume,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_valid
);

    logic [PC_W-1:0]    r_slot_pc;
    logic [INSTR_W-1:0] r_slot_instr;
    logic               r_slot_valid;
    logic [PC_W-1:0]    r_hold_pc;
    logic [INSTR_W-1:0] r_hold_instr;

    // NOTE: both entries are only two words wide, so they get a full reset;
    // that keeps instr_o at the bubble value straight out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot_pc    <= '0;
            r_slot_instr <= NOP_INSTR;
            r_slot_valid <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= NOP_INSTR;
        end else if (i_invalidate) begin
            r_slot_pc    <= '0;
            r_slot_instr <= NOP_INSTR;
            r_slot_valid <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= NOP_INSTR;
        end else begin
            // A fresh word or the parked word replaces the slot; a consumed
            // slot with no replacement falls back to a bubble.
            if (i_load_slot) begin
                r_slot_pc    <= i_pc;
                r_slot_instr <= i_instr;
                r_slot_valid <= 1'b1;
            end else if (i_hold_to_slot) begin
                r_slot_pc    <= r_hold_pc;
                r_slot_instr <= r_hold_instr;
                r_slot_valid <= 1'b1;
            end else if (i_consume) begin
                r_slot_pc    <= '0;
                r_slot_instr <= NOP_INSTR;
                r_slot_valid <= 1'b0;
            end

            if (i_load_hold) begin
                r_hold_pc    <= i_pc;
                r_hold_instr <= i_instr;
            end
        end
    end

    assign o_pc    = r_slot_pc;
    assign o_instr = r_slot_instr;
    assign o_valid = r_slot_valid;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage ahead of IF/ID. Owns the PC, runs one outstanding
// request at a time against instruction memory (req/ack), and presents
// (PC, instruction, valid) to IF/ID. Honours stalls and branch redirects and
// presents zero bubbles when nothing has been fetched.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   Stall_i             IF/ID will not accept this cycle
//   Branch_i            single-cycle redirect request
//   BranchTarget_i      redirect PC (bits [1:0] ignored)
//   imem_req_o          one-cycle request strobe
//   imem_addr_o         request address
//   imem_ack_i          response strobe, imem_data_i valid with it
//   imem_data_i         instruction word
//   PC_o, instr_o       presented pair
//   valid_o             presented pair is a real instruction
//   FetchStall_o        IF/ID must take a bubble this cycle
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               Stall_i,
    input  logic               Branch_i,
    input  logic [PC_W-1:0]    BranchTarget_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [PC_W-1:0]    PC_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o,
    output logic               FetchStall_o
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_kill;
    logic            w_kill_nxt;

    logic            w_slot_valid;
    logic            w_consume;
    logic            w_load_slot;
    logic            w_load_hold;
    logic            w_hold_to_slot;

    assign w_consume = w_slot_valid & ~Stall_i;

    // NOTE: every signal gets its default before the branches below, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_kill_nxt     = r_kill;
        w_load_slot    = 1'b0;
        w_load_hold    = 1'b0;
        w_hold_to_slot = 1'b0;

        if (Branch_i) begin
            // Redirect wins over everything, stalled or not.
            w_pc_nxt    = align_pc(BranchTarget_i);
            w_state_nxt = ST_REQ;
            w_kill_nxt  = 1'b0;
            // A request still in flight must have its response swallowed.
            // If that response lands this very cycle it is simply dropped.
            if (r_state == ST_WAIT && !imem_ack_i) begin
                w_state_nxt = ST_WAIT;
                w_kill_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                ST_REQ: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (imem_ack_i) begin
                        if (r_kill) begin
                            w_kill_nxt  = 1'b0;
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_pc_nxt = r_pc + PC_INC;
                            if (!w_slot_valid || w_consume) begin
                                w_load_slot = 1'b1;
                                w_state_nxt = ST_REQ;
                            end else begin
                                w_load_hold = 1'b1;
                                w_state_nxt = ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_consume) begin
                        w_hold_to_slot = 1'b1;
                        w_state_nxt    = ST_REQ;
                    end
                end
                default: w_state_nxt = ST_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .i_invalidate   (Branch_i),
        .i_load_slot    (w_load_slot),
        .i_load_hold    (w_load_hold),
        .i_hold_to_slot (w_hold_to_slot),
        .i_consume      (w_consume),
        .i_pc           (r_pc),
        .i_instr        (imem_data_i),
        .o_pc           (PC_o),
        .o_instr        (instr_o),
        .o_valid        (w_slot_valid)
    );

    // The request is dropped in a redirect cycle so the stale address never
    // reaches memory.
    assign imem_req_o   = (r_state == ST_REQ) && !Branch_i;
    assign imem_addr_o  = r_pc;
    assign valid_o      = w_slot_valid;
    assign FetchStall_o = ~w_slot_valid & ~Stall_i;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed per-cycle vectors for fetch_unit: each record holds the inputs for
// one cycle and the outputs expected in that cycle (sampled at the falling
// edge). Reset behaviour is exercised by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] target;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fstall;
    } vec_t;

    logic        clk_i;
    logic        rst_i;
    logic        Stall_i;
    logic        Branch_i;
    logic [31:0] BranchTarget_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] PC_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        FetchStall_o;

    int n_vec;
    int n_bad;

    vec_t vecs[$];
    vec_t rvecs[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Stall_i        (Stall_i),
        .Branch_i       (Branch_i),
        .BranchTarget_i (BranchTarget_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .PC_o           (PC_o),
        .instr_o        (instr_o),
        .valid_o        (valid_o),
        .FetchStall_o   (FetchStall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory contents as the bench defines them.
    function automatic logic [31:0] w(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                                input logic ak, input logic [31:0] d,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_pc,
                                input logic [31:0] e_ins);
        vec_t v;
        v.stall    = st;
        v.branch   = br;
        v.target   = tgt;
        v.ack      = ak;
        v.data     = d;
        v.e_req    = e_req;
        v.e_addr   = e_addr;
        v.e_valid  = e_val;
        v.e_pc     = e_pc;
        v.e_instr  = e_ins;
        v.e_fstall = !e_val && !st;
        return v;
    endfunction

    task automatic check(input string name, input logic [97:0] got, input logic [97:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h fstall=%b, want req=%b addr=%h valid=%b pc=%h instr=%h fstall=%b",
                     name, got[97], got[96:65], got[64], got[63:32], got[31:0], exp[0],
                     exp[97], exp[96:65], exp[64], exp[63:32], exp[31:0], exp[0]);
        end
    endtask

    function automatic logic [97:0] outs_now();
        return {imem_req_o, imem_addr_o, valid_o, PC_o, instr_o[31:1], instr_o[0] ^ 1'b0} ^
               {97'd0, 1'b0} | 98'd0;
    endfunction

    // Drive one cycle's inputs just after the rising edge, check at the
    // falling edge, then advance to just past the next rising edge.
    task automatic apply(input vec_t v, input string name);
        logic [97:0] got;
        logic [97:0] exp;
        Stall_i        = v.stall;
        Branch_i       = v.branch;
        BranchTarget_i = v.target;
        imem_ack_i     = v.ack;
        imem_data_i    = v.data;
        @(negedge clk_i);
        got = {imem_req_o, imem_addr_o, valid_o, PC_o, instr_o};
        exp = {v.e_req, v.e_addr, v.e_valid, v.e_pc, v.e_instr};
        check({name, " outputs"}, got, exp);
        n_vec++;
        if (FetchStall_o !== v.e_fstall) begin
            n_bad++;
            $display("FAIL %s FetchStall_o: got %b want %b", name, FetchStall_o, v.e_fstall);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_check(input string name);
        check(name, {imem_req_o, imem_addr_o, valid_o, PC_o, instr_o},
              {1'b1, 32'h0, 1'b0, 32'h0, 32'h0});
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_i = 1'b1;
        Stall_i = 1'b0;
        Branch_i = 1'b0;
        BranchTarget_i = '0;
        imem_ack_i = 1'b0;
        imem_data_i = '0;

        //            st br target        ack data           req addr          val pc            instr
        // Back-to-back fetch with a 1-cycle memory: 0,4,8.
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0,        0, 0,            0));            // c0
        vecs.push_back(mk(0, 0, 0,            1, w(32'h0),     0, 32'h0,        0, 0,            0));            // c1
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h4,        1, 32'h0,        w(32'h0)));     // c2
        vecs.push_back(mk(0, 0, 0,            1, w(32'h4),     0, 32'h4,        0, 0,            0));            // c3
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h8,        1, 32'h4,        w(32'h4)));     // c4
        vecs.push_back(mk(0, 0, 0,            1, w(32'h8),     0, 32'h8,        0, 0,            0));            // c5
        // Five stalled cycles: second word parks in HOLD, no further request.
        vecs.push_back(mk(1, 0, 0,            0, 0,            1, 32'hC,        1, 32'h8,        w(32'h8)));     // c6
        vecs.push_back(mk(1, 0, 0,            1, w(32'hC),     0, 32'hC,        1, 32'h8,        w(32'h8)));     // c7
        vecs.push_back(mk(1, 0, 0,            0, 0,            0, 32'h10,       1, 32'h8,        w(32'h8)));     // c8
        vecs.push_back(mk(1, 0, 0,            0, 0,            0, 32'h10,       1, 32'h8,        w(32'h8)));     // c9
        vecs.push_back(mk(1, 0, 0,            0, 0,            0, 32'h10,       1, 32'h8,        w(32'h8)));     // c10
        vecs.push_back(mk(0, 0, 0,            0, 0,            0, 32'h10,       1, 32'h8,        w(32'h8)));     // c11
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h10,       1, 32'hC,        w(32'hC)));     // c12
        vecs.push_back(mk(0, 0, 0,            1, w(32'h10),    0, 32'h10,       0, 0,            0));            // c13
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h14,       1, 32'h10,       w(32'h10)));    // c14
        // Branch while WAIT; killed ack three cycles later.
        vecs.push_back(mk(0, 1, 32'h102,      0, 0,            0, 32'h14,       0, 0,            0));            // c15
        vecs.push_back(mk(0, 0, 0,            0, 0,            0, 32'h100,      0, 0,            0));            // c16
        vecs.push_back(mk(0, 0, 0,            0, 0,            0, 32'h100,      0, 0,            0));            // c17
        vecs.push_back(mk(0, 0, 0,            1, 32'hDEADBEEF, 0, 32'h100,      0, 0,            0));            // c18
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h100,      0, 0,            0));            // c19
        vecs.push_back(mk(0, 0, 0,            1, w(32'h100),   0, 32'h100,      0, 0,            0));            // c20
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h104,      1, 32'h100,      w(32'h100)));   // c21
        // Branch coincident with ack: response dropped, target next cycle.
        vecs.push_back(mk(0, 1, 32'h200,      1, w(32'h104),   0, 32'h104,      0, 0,            0));            // c22
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h200,      0, 0,            0));            // c23
        vecs.push_back(mk(0, 0, 0,            1, w(32'h200),   0, 32'h200,      0, 0,            0));            // c24
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h204,      1, 32'h200,      w(32'h200)));   // c25
        vecs.push_back(mk(0, 0, 0,            1, w(32'h204),   0, 32'h204,      0, 0,            0));            // c26
        // Branch under stall in REQ: request suppressed, slot flushed,
        // low target bits forced to zero; then PC wrap at the top of memory.
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0,           0, 32'h208,      1, 32'h204,      w(32'h204)));   // c27
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'hFFFF_FFFC, 0, 0,           0));            // c28
        vecs.push_back(mk(0, 0, 0,            1, 32'h1234_5678, 0, 32'hFFFF_FFFC, 0, 0,          0));            // c29
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC, 32'h1234_5678)); // c30
        vecs.push_back(mk(0, 0, 0,            1, w(32'h0),     0, 32'h0,        0, 0,            0));            // c31
        // Ack while in REQ is ignored.
        vecs.push_back(mk(0, 0, 0,            1, 32'h0000_0BAD, 1, 32'h4,       1, 32'h0,        w(32'h0)));     // c32
        vecs.push_back(mk(0, 0, 0,            0, 0,            0, 32'h4,        0, 0,            0));            // c33
        vecs.push_back(mk(0, 0, 0,            1, w(32'h4),     0, 32'h4,        0, 0,            0));            // c34
        vecs.push_back(mk(0, 0, 0,            0, 0,            1, 32'h8,        1, 32'h4,        w(32'h4)));     // c35

        // After a mid-request reset: stale ack lands in REQ and is ignored;
        // then a slot consumed in the same cycle as the next ack is refilled
        // directly rather than through HOLD.
        rvecs.push_back(mk(0, 0, 0,           1, 32'h0000_0BAD, 1, 32'h0,       0, 0,            0));            // r0
        rvecs.push_back(mk(0, 0, 0,           0, 0,            0, 32'h0,        0, 0,            0));            // r1
        rvecs.push_back(mk(0, 0, 0,           1, w(32'h0),     0, 32'h0,        0, 0,            0));            // r2
        rvecs.push_back(mk(1, 0, 0,           0, 0,            1, 32'h4,        1, 32'h0,        w(32'h0)));     // r3
        rvecs.push_back(mk(0, 0, 0,           1, w(32'h4),     0, 32'h4,        1, 32'h0,        w(32'h0)));     // r4
        rvecs.push_back(mk(0, 0, 0,           0, 0,            1, 32'h8,        1, 32'h4,        w(32'h4)));     // r5

        repeat (2) @(posedge clk_i);
        #1;
        reset_check("reset state");
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec c%0d", i));

        // Now in WAIT with the request for 8 outstanding; reset mid-cycle.
        Stall_i = 1'b0;
        Branch_i = 1'b0;
        imem_ack_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        reset_check("async reset mid-request");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < rvecs.size(); i++)
            apply(rvecs[i], $sformatf("vec r%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
